reflet_gpio_sequencer: RTL

Memory-mapped pattern sequencer that autonomously drives a 16-bit GPO bank from an 8-entry pattern table. Each entry is held for a programmable number of clock cycles. Sequences run once or loop, and completion can raise an interrupt. The block sits on the 8-bit system bus beside the GPIO peripheral, so software can play timed waveforms without per-step CPU writes.

---
 rtl/reflet_gpio_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/reflet_gpio_sequencer.sv
// Memory-mapped pattern sequencer: plays an 8-entry table of 16-bit patterns onto a GPO bank,
// holding each entry for PRESC+1 cycles, once or looping, with an optional completion interrupt.
module reflet_gpio_sequencer #(
  parameter int unsigned                   base_addr_size = 16,
  parameter logic [base_addr_size-1:0]     base_addr      = 16'hFF10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      interrupt,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  output logic [15:0]               gpo
);

  localparam int unsigned AW = base_addr_size + 1;

  localparam logic [4:0] OFF_CTRL     = 5'd0;
  localparam logic [4:0] OFF_STATUS   = 5'd1;
  localparam logic [4:0] OFF_PRESC_LO = 5'd2;
  localparam logic [4:0] OFF_PRESC_HI = 5'd3;
  localparam logic [4:0] OFF_LEN      = 5'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        loop_q, loop_d;
  logic        int_en_q, int_en_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  len_q, len_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] gpo_q, gpo_d;
  logic        irq_q, irq_d;
  logic [15:0] pattern_q [8];
  logic [15:0] pattern_d [8];

  // Window end is computed one bit wider so a window touching the top of the map cannot wrap.
  logic [AW-1:0] addr_ext;
  logic [AW-1:0] win_end;
  logic          selected;
  logic          wr;
  logic [4:0]    offset;
  logic          start;
  logic          stop;

  assign addr_ext = {1'b0, addr};
  assign win_end  = {1'b0, base_addr} + AW'(32);
  assign selected = enable && (addr >= base_addr) && (addr_ext < win_end);
  assign offset   = addr[4:0] - base_addr[4:0];
  assign wr       = selected && write_en;
  assign start    = wr && (offset == OFF_CTRL) && data_in[0];
  assign stop     = wr && (offset == OFF_CTRL) && data_in[1];

  // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    loop_d    = loop_q;
    int_en_d  = int_en_q;
    idx_d     = idx_q;
    len_d     = len_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    gpo_d     = gpo_q;
    irq_d     = 1'b0;
    pattern_d = pattern_q;

    if (wr) begin
      case (offset)
        OFF_CTRL: begin
          loop_d   = data_in[2];
          int_en_d = data_in[3];
        end
        // Clearing only applies to a DONE already latched, so a completion on this edge wins.
        OFF_STATUS:   if (data_in[1] && (state_q == S_DONE)) state_d = S_IDLE;
        OFF_PRESC_LO: presc_d[7:0]  = data_in;
        OFF_PRESC_HI: presc_d[15:8] = data_in;
        OFF_LEN:      len_d = data_in[2:0];
        default: begin
          if (offset[4]) begin
            if (offset[0]) pattern_d[offset[3:1]][15:8] = data_in;
            else           pattern_d[offset[3:1]][7:0]  = data_in;
          end
        end
      endcase
    end

    if (stop) begin
      idx_d = '0;
      if (state_q == S_RUN) state_d = S_IDLE;
    end else if (start) begin
      idx_d   = '0;
      gpo_d   = pattern_q[0];
      cnt_d   = presc_q;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 16'd1;
      end else if (idx_q < len_q) begin
        idx_d = idx_q + 3'd1;
        gpo_d = pattern_q[idx_q + 3'd1];
        cnt_d = presc_q;
      end else if (loop_q) begin
        idx_d = '0;
        gpo_d = pattern_q[0];
        cnt_d = presc_q;
      end else begin
        idx_d   = '0;
        state_d = S_DONE;
        irq_d   = int_en_q;
      end
    end
  end

  // NOTE: state uses non-blocking '<='; the pattern table is reset too because software may read it back after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      loop_q    <= 1'b0;
      int_en_q  <= 1'b0;
      idx_q     <= '0;
      len_q     <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      gpo_q     <= '0;
      irq_q     <= 1'b0;
      pattern_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      loop_q    <= loop_d;
      int_en_q  <= int_en_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      gpo_q     <= gpo_d;
      irq_q     <= irq_d;
      pattern_q <= pattern_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (selected) begin
      case (offset)
        OFF_CTRL:     data_out = {4'b0, int_en_q, loop_q, 2'b0};
        OFF_STATUS:   data_out = {1'b0, idx_q, 2'b0, state_q == S_DONE, state_q == S_RUN};
        OFF_PRESC_LO: data_out = presc_q[7:0];
        OFF_PRESC_HI: data_out = presc_q[15:8];
        OFF_LEN:      data_out = {5'b0, len_q};
        default: begin
          if (offset[4]) data_out = offset[0] ? pattern_q[offset[3:1]][15:8] : pattern_q[offset[3:1]][7:0];
        end
      endcase
    end
  end

  assign gpo       = gpo_q;
  assign interrupt = irq_q;

endmodule
